// File: rtl/dma_priority_arbiter.sv
// -----------------------------------------------------------------------------
// dma_priority_arbiter
//   Priority and bus-request controller for a 4-channel DMA. It synchronizes
//   the asynchronous DREQ pins and qualifies them with the mask and the software
//   request bits. It runs the HRQ/HLDA hold handshake with the CPU and grants
//   one channel per service, using either fixed or rotating priority.
//
//   State table:
//     IDLE    | bus not requested; watching for a qualified request
//     REQ     | HRQ raised, waiting for HLDA
//     GRANT   | channel granted; ACTIVE_CH/DACK frozen until done or bus loss
//     RELEASE | HRQ dropped, waiting for the CPU to drop HLDA
//
// Ports:
//   clk_i, reset_i      system clock, synchronous active-high reset
//   dreq_i[3:0]         asynchronous channel requests (polarity: dreq_sense_low_i)
//   sw_req_i[3:0]       software requests, synchronous, not maskable
//   mask_i[3:0]         1 = ignore the hardware DREQ of that channel
//   ctrl_disable_i      1 = do not raise a new HRQ
//   rot_pri_i           0 = fixed priority (ch0 highest), 1 = rotating
//   dreq_sense_low_i    1 = DREQ pins are active-low
//   dack_sense_high_i   1 = DACK pins are active-high
//   hlda_i              hold acknowledge from the CPU (synchronous)
//   xfer_done_i         one-cycle pulse: the current service has finished
//   hrq_o               hold request to the CPU
//   dack_o[3:0]         channel acknowledges at the programmed polarity
//   active_ch_o[1:0]    index of the granted channel
//   grant_valid_o       1 while a channel is granted
//   bus_lost_o          one-cycle pulse: HLDA dropped during a grant
// -----------------------------------------------------------------------------
module dma_priority_arbiter #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [NCH-1:0] dreq_i,
    input  logic [NCH-1:0] sw_req_i,
    input  logic [NCH-1:0] mask_i,
    input  logic           ctrl_disable_i,
    input  logic           rot_pri_i,
    input  logic           dreq_sense_low_i,
    input  logic           dack_sense_high_i,
    input  logic           hlda_i,
    input  logic           xfer_done_i,
    output logic           hrq_o,
    output logic [NCH-1:0] dack_o,
    output logic [1:0]     active_ch_o,
    output logic           grant_valid_o,
    output logic           bus_lost_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] ack_q;
    logic [1:0]     active_ch_q;
    logic [1:0]     ptr_q;
    logic           hrq_q;
    logic           grant_valid_q;
    logic           bus_lost_q;

    logic [NCH-1:0] pending;
    logic [1:0]     ptr_eff;
    logic [1:0]     cand;
    logic [1:0]     sel_ch;

    // Polarity is normalised before the synchronizer so the flops reset to
    // the inactive level, whichever pin sense is programmed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= dreq_i ^ {NCH{dreq_sense_low_i}};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pending = (sync_q[SYNC_STAGES-1] & ~mask_i) | sw_req_i;

    // Scan from the lowest priority to the highest so that the highest
    // priority pending channel overwrites the others. The pointer is treated
    // as zero in fixed mode, even during the cycle when ROT_PRI first drops.
    always_comb begin
        ptr_eff = rot_pri_i ? ptr_q : 2'd0;
        sel_ch  = 2'd0;
        cand    = 2'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = ptr_eff + 2'(k);
            if (pending[cand]) begin
                sel_ch = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            hrq_q         <= 1'b0;
            ack_q         <= '0;
            active_ch_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            bus_lost_q    <= 1'b0;
            ptr_q         <= 2'd0;
        end else begin
            bus_lost_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((|pending) && !ctrl_disable_i) begin
                        hrq_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (hlda_i) begin
                        if (|pending) begin
                            active_ch_q   <= sel_ch;
                            ack_q         <= NCH'(1) << sel_ch;
                            grant_valid_q <= 1'b1;
                            state_q       <= GRANT;
                        end else begin
                            // The bus arrived after the request went away.
                            // Give it back without acknowledging any channel.
                            hrq_q   <= 1'b0;
                            state_q <= RELEASE;
                        end
                    end else if (!(|pending)) begin
                        hrq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (xfer_done_i) begin
                        ack_q         <= '0;
                        grant_valid_q <= 1'b0;
                        hrq_q         <= 1'b0;
                        ptr_q         <= active_ch_q + 2'd1;
                        // If HLDA has already gone, there is nothing left to wait for.
                        state_q       <= hlda_i ? RELEASE : IDLE;
                    end else if (!hlda_i) begin
                        ack_q         <= '0;
                        grant_valid_q <= 1'b0;
                        hrq_q         <= 1'b0;
                        bus_lost_q    <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                RELEASE: begin
                    if (!hlda_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Fixed mode pins the pointer to zero and overrides any rotation above.
            if (!rot_pri_i) begin
                ptr_q <= 2'd0;
            end
        end
    end

    assign hrq_o         = hrq_q;
    assign active_ch_o   = active_ch_q;
    assign grant_valid_o = grant_valid_q;
    assign bus_lost_o    = bus_lost_q;
    assign dack_o        = ack_q ^ {NCH{~dack_sense_high_i}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dreq = 4'h0;
    logic [3:0] sw_req = 4'h0;
    logic [3:0] mask = 4'h0;
    logic       ctrl_dis = 1'b0;
    logic       rot = 1'b0;
    logic       dsl = 1'b0;
    logic       dsh = 1'b0;
    logic       hlda = 1'b0;
    logic       xfer = 1'b0;

    logic       hrq_o;
    logic [3:0] dack_o;
    logic [1:0] active_ch_o;
    logic       grant_valid_o;
    logic       bus_lost_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model. The bus is described by three facts: whether HRQ is
    // raised, whether a channel is owned, and whether the bench is waiting
    // for HLDA to go away. The DREQ synchronizer is a fixed-length delay queue.
    logic [3:0] sq[$];
    bit         m_hrq, m_granted, m_rel, m_lost;
    int         m_ch, m_ptr;

    dma_priority_arbiter #(.NCH(4), .SYNC_STAGES(2)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .dreq_i           (dreq),
        .sw_req_i         (sw_req),
        .mask_i           (mask),
        .ctrl_disable_i   (ctrl_dis),
        .rot_pri_i        (rot),
        .dreq_sense_low_i (dsl),
        .dack_sense_high_i(dsh),
        .hlda_i           (hlda),
        .xfer_done_i      (xfer),
        .hrq_o            (hrq_o),
        .dack_o           (dack_o),
        .active_ch_o      (active_ch_o),
        .grant_valid_o    (grant_valid_o),
        .bus_lost_o       (bus_lost_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] p, input int base);
        for (int k = 0; k < 4; k++) begin
            if (p[(base + k) % 4]) return (base + k) % 4;
        end
        return 0;
    endfunction

    // One clock: predict from the inputs now applied, clock the DUT, compare.
    task automatic tick();
        logic [3:0] pend;
        logic [3:0] raw;
        logic [3:0] a;
        bit n_hrq, n_gr, n_rel, n_lost;
        int n_ch, n_ptr, sel;
        pend   = (sq[0] & ~mask) | sw_req;
        raw    = dreq ^ {4{dsl}};
        sel    = pick(pend, rot ? m_ptr : 0);
        n_hrq  = m_hrq;  n_gr = m_granted; n_rel = m_rel;
        n_ch   = m_ch;   n_ptr = m_ptr;    n_lost = 0;
        if (rst) begin
            n_hrq = 0; n_gr = 0; n_rel = 0; n_ch = 0; n_ptr = 0;
        end else if (m_granted) begin
            if (xfer) begin
                n_gr = 0; n_hrq = 0; n_rel = hlda;
                if (rot) n_ptr = (m_ch + 1) % 4;
            end else if (!hlda) begin
                n_gr = 0; n_hrq = 0; n_lost = 1;
            end
        end else if (m_rel) begin
            if (!hlda) n_rel = 0;
        end else if (m_hrq) begin
            if (hlda) begin
                if (pend != 0) begin n_gr = 1; n_ch = sel; end
                else begin n_hrq = 0; n_rel = 1; end
            end else if (pend == 0) begin
                n_hrq = 0;
            end
        end else if (pend != 0 && !ctrl_dis) begin
            n_hrq = 1;
        end
        if (!rot) n_ptr = 0;

        @(posedge clk);
        #1;
        if (rst) begin
            sq.delete(); sq.push_back(4'h0); sq.push_back(4'h0);
        end else begin
            sq.push_back(raw);
            void'(sq.pop_front());
        end
        m_hrq = n_hrq; m_granted = n_gr; m_rel = n_rel; m_lost = n_lost;
        m_ch = n_ch; m_ptr = n_ptr;

        a = m_granted ? (4'b0001 << m_ch) : 4'b0000;
        chk("hrq", hrq_o, m_hrq);
        chk("grant_valid", grant_valid_o, m_granted);
        chk("active_ch", active_ch_o, m_ch);
        chk("bus_lost", bus_lost_o, m_lost);
        chk("dack", dack_o, a ^ {4{~dsh}});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_hrq(input string tag);
        int n = 0;
        while (hrq_o !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk(tag, hrq_o, 1);
    endtask

    initial begin
        sq.push_back(4'h0); sq.push_back(4'h0);
        m_hrq = 0; m_granted = 0; m_rel = 0; m_lost = 0; m_ch = 0; m_ptr = 0;

        // Reset state
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        chk("rst_hrq", hrq_o, 0);
        chk("rst_dack", dack_o, 4'hF);
        chk("rst_gv", grant_valid_o, 0);

        // Fixed priority, DREQ latency of three edges
        dreq = 4'b1010;
        ticks(2);
        chk("fix_hrq_early", hrq_o, 0);
        tick();
        chk("fix_hrq", hrq_o, 1);
        hlda = 1'b1;
        tick();
        chk("fix_ch", active_ch_o, 1);
        chk("fix_dack", dack_o, 4'b1101);
        tick();
        xfer = 1'b1; dreq = 4'h0;
        tick();
        chk("fix_done_dack", dack_o, 4'hF);
        chk("fix_done_hrq", hrq_o, 0);
        xfer = 1'b0; hlda = 1'b0;
        ticks(2);

        // Rotating priority with all channels requesting
        rot = 1'b1; dreq = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_hrq("rot_hrq");
            hlda = 1'b1;
            tick();
            chk("rot_ch", active_ch_o, i);
            tick();
            xfer = 1'b1;
            tick();
            xfer = 1'b0; hlda = 1'b0;
            tick();
        end

        // Masked hardware requests, then an unmaskable software request
        mask = 4'hF; rot = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mask_hrq", hrq_o, 0);
        end
        sw_req = 4'b0100;
        tick();
        chk("sw_hrq", hrq_o, 1);
        hlda = 1'b1;
        tick();
        chk("sw_ch", active_ch_o, 2);
        chk("sw_dack", dack_o, 4'b1011);
        xfer = 1'b1; sw_req = 4'h0;
        tick();
        xfer = 1'b0; hlda = 1'b0;
        tick();
        dreq = 4'h0;
        ticks(3);
        mask = 4'h0;
        tick();

        // Request withdrawn between HRQ and HLDA
        dreq = 4'b1000;
        ticks(2);
        chk("wd_hrq_early", hrq_o, 0);
        tick();
        chk("wd_hrq", hrq_o, 1);
        dreq = 4'h0;
        ticks(2);
        hlda = 1'b1;
        tick();
        chk("wd_hrq_rel", hrq_o, 0);
        chk("wd_gv", grant_valid_o, 0);
        chk("wd_dack", dack_o, 4'hF);
        tick();
        hlda = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wd_hrq_after", hrq_o, 0);
        end

        // Bus loss on ch0: pointer stays put
        rot = 1'b1; dreq = 4'b0001;
        wait_hrq("bl_hrq");
        hlda = 1'b1;
        tick();
        chk("bl_ch", active_ch_o, 0);
        tick();
        hlda = 1'b0;
        tick();
        chk("bl_pulse", bus_lost_o, 1);
        chk("bl_dack", dack_o, 4'hF);
        chk("bl_gv", grant_valid_o, 0);
        dreq = 4'hF;
        tick();
        chk("bl_pulse_end", bus_lost_o, 0);
        tick();
        wait_hrq("bl_hrq2");
        hlda = 1'b1;
        tick();
        chk("bl_ptr_kept", active_ch_o, 0);
        tick();
        // Done and bus loss together: treated as done, pointer rotates
        xfer = 1'b1; hlda = 1'b0;
        tick();
        chk("bx_no_lost", bus_lost_o, 0);
        chk("bx_hrq", hrq_o, 0);
        chk("bx_dack", dack_o, 4'hF);
        xfer = 1'b0;
        wait_hrq("bx_hrq2");
        hlda = 1'b1;
        tick();
        chk("bx_ptr_rot", active_ch_o, 1);
        xfer = 1'b1;
        tick();
        xfer = 1'b0; hlda = 1'b0;
        tick();

        // Reset mid-grant with active-high DACK, then CTRL_DISABLE
        rot = 1'b0; dreq = 4'h0;
        ticks(5);
        dsh = 1'b1; dreq = 4'b0100;
        wait_hrq("rg_hrq");
        hlda = 1'b1;
        tick();
        chk("rg_dack", dack_o, 4'b0100);
        tick();
        rst = 1'b1;
        tick();
        chk("rg_dack_rst", dack_o, 4'b0000);
        chk("rg_hrq_rst", hrq_o, 0);
        chk("rg_gv_rst", grant_valid_o, 0);
        chk("rg_lost_rst", bus_lost_o, 0);
        rst = 1'b0; hlda = 1'b0; ctrl_dis = 1'b1; dreq = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("dis_hrq", hrq_o, 0);
        end
        ctrl_dis = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit idle;
            idle = !m_hrq && !m_granted && !m_rel;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 4) == 0)  dreq = 4'($urandom);
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
            sw_req = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 9) == 0)  ctrl_dis = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rot = 1'($urandom_range(0, 1));
            if (idle && $urandom_range(0, 19) == 0) begin
                dsl = 1'($urandom_range(0, 1));
                dsh = 1'($urandom_range(0, 1));
            end
            if (m_hrq && !hlda && $urandom_range(0, 2) == 0) hlda = 1'b1;
            else if (hlda && !m_hrq && $urandom_range(0, 1) == 0) hlda = 1'b0;
            else if (hlda && m_hrq && $urandom_range(0, 15) == 0) hlda = 1'b0;
            xfer = m_granted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Priority and bus-request controller of the 4-channel DMA.
- Synchronizes and qualifies the asynchronous DREQ lines, runs the HRQ/HLDA hold handshake with the CPU, and selects one channel per service using fixed or rotating priority.
- Drives DACK to the peripheral and tells the timing-control block which channel is active.
- Sits between the external request pins and the timing-control/datapath blocks.

Parameters:
- NCH, 4, number of channels; the design is fixed at 4 and only 4 is supported.
- SYNC_STAGES, 2, flip-flop stages on each DREQ input.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  4  asynchronous channel requests; polarity set by DREQ_SENSE_LOW.
- SW_REQ  input  4  software request bits from the datapath request register; already synchronous; not maskable.
- MASK  input  4  channel mask bits from the datapath; 1 = hardware DREQ ignored.
- CTRL_DISABLE  input  1  command bit; 1 = no new HRQ is raised.
- ROT_PRI  input  1  command bit; 0 = fixed priority, 1 = rotating priority.
- DREQ_SENSE_LOW  input  1  1 = DREQ is active-low.
- DACK_SENSE_HIGH  input  1  1 = DACK is active-high.
- HLDA  input  1  hold acknowledge; synchronous to CLK.
- XFER_DONE  input  1  one-cycle pulse from timing control: current service finished (TC, EOP or single-transfer end).
- HRQ  output  1  hold request to the CPU.
- DACK  output  4  channel acknowledges, at the programmed polarity.
- ACTIVE_CH  output  2  index of the granted channel.
- GRANT_VALID  output  1  1 while a channel is granted.
- BUS_LOST  output  1  one-cycle pulse: HLDA dropped during a grant.

Behaviour:
- Reset state:
  - HRQ=0, GRANT_VALID=0, BUS_LOST=0, ACTIVE_CH=0.
  - Internal ack=0, so DACK is at the inactive level (4'b1111 when DACK_SENSE_HIGH=0, 4'b0000 when 1).
  - FSM=IDLE, priority pointer=0, all sync flops at the inactive level.
- Output decode:
  - dreq_act = DREQ XOR {4{DREQ_SENSE_LOW}}, taken after SYNC_STAGES flops.
  - DACK = ack_int XOR {4{~DACK_SENSE_HIGH}}; the only combinational output.
- Request qualification: pending = (dreq_sync & ~MASK) | SW_REQ.
- Priority order:
  - Fixed: ch0 > ch1 > ch2 > ch3.
  - Rotating: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - While ROT_PRI=0, ptr is forced to 0 every cycle.
- FSM, all outputs registered:
  - IDLE: if (|pending) and !CTRL_DISABLE, go to REQ; HRQ=1 from the next cycle.
  - REQ: HRQ=1.
    - HLDA=1 and |pending: latch the highest-priority pending channel into ACTIVE_CH. Next cycle: ack_int one-hot, GRANT_VALID=1. Go to GRANT.
    - HLDA=1 and pending=0 (request withdrawn): go to RELEASE.
    - HLDA=0 and pending=0: return to IDLE, HRQ=0.
    - CTRL_DISABLE does not cancel a REQ already in progress.
  - GRANT: ACTIVE_CH and ack_int are frozen; changes on DREQ/MASK/SW_REQ are ignored.
    - XFER_DONE=1: next cycle ack_int=0, GRANT_VALID=0, HRQ=0. If ROT_PRI=1, ptr=(ACTIVE_CH+1) mod 4. Go to RELEASE.
    - HLDA=0 (bus lost) with no XFER_DONE: next cycle ack_int=0, GRANT_VALID=0, HRQ=0, BUS_LOST=1 for 1 cycle. ptr unchanged. Go to IDLE.
    - XFER_DONE and HLDA=0 in the same cycle: handled as XFER_DONE (rotate, no BUS_LOST), then straight to IDLE.
  - RELEASE: HRQ=0; wait for HLDA=0, then go to IDLE. No new HRQ may be raised until IDLE.
- Latency:
  - Hardware DREQ active before edge k gives HRQ=1 after edge k+SYNC_STAGES (3 edges with default).
  - SW_REQ gives HRQ after 1 edge.
  - HLDA sampled high at edge n gives DACK active after edge n.
  - XFER_DONE at edge m gives DACK inactive and HRQ=0 after edge m.
- XFER_DONE outside GRANT is ignored.
- RESET asserted in any state: all outputs go to their reset values after the next edge. The bus is released without BUS_LOST.
- Polarity inputs may change only while in IDLE; other behaviour is undefined.

Test Plan:
- Fixed priority: ROT_PRI=0, MASK=0, DREQ_SENSE_LOW=0, DREQ=4'b1010 → HRQ=1 after 3 edges; HLDA=1 → ACTIVE_CH=1, DACK=4'b1101 (active-low). XFER_DONE → DACK=4'b1111, HRQ=0.
- Rotating: ROT_PRI=1, DREQ=4'b1111 held, three services each ended by XFER_DONE and HLDA low/high → grants are ch0, ch1, ch2; ptr=3 after the third service.
- Mask and software request: MASK=4'b1111, DREQ=4'b1111 → HRQ stays 0 for 10 cycles. SW_REQ=4'b0100 → HRQ=1 after 1 edge, grant ACTIVE_CH=2.
- Handshake corner: assert DREQ[3], drop it after HRQ=1 but before HLDA → on HLDA=1, no DACK and FSM goes to RELEASE. After HLDA=0, HRQ stays 0.
- Bus loss: in GRANT on ch0, drop HLDA with no XFER_DONE → BUS_LOST=1 for exactly one cycle, DACK inactive, ptr unchanged. Repeat with XFER_DONE and HLDA falling in the same cycle → BUS_LOST=0 and ptr rotates.
- Reset and polarity: RESET mid-GRANT with DACK_SENSE_HIGH=1 → DACK=4'b0000, HRQ=0, GRANT_VALID=0 after one edge. CTRL_DISABLE=1 with DREQ active → HRQ stays 0.
